// File: rtl/add3_pkg.sv
// add3_pkg: shared constants, scheduler state encoding and psum type for the add3 accumulator.
package add3_pkg;
  localparam int LANES = 3;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int LEN_W = 8;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sched_state_t;
  typedef logic signed [AW-1:0] psum_t;
endpackage

// File: rtl/add3_lane_acc.sv
// add3_lane_acc: one lane, sign-extended act+wgt added into a wrapping accumulator.
module add3_lane_acc #(
  parameter int DW = add3_pkg::DW,
  parameter int AW = add3_pkg::AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [DW-1:0]        act,
  input  logic [DW-1:0]        wgt,
  output logic signed [AW-1:0] acc
);
  logic [DW:0] sum;
  logic [AW-1:0] acc_q, acc_d;
  assign sum = {act[DW-1], act} + {wgt[DW-1], wgt};
  assign acc_d = clr ? '0 : en ? acc_q + {{(AW-DW-1){sum[DW]}}, sum} : acc_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) acc_q <= '0;
    else acc_q <= acc_d;
  assign acc = acc_q;
endmodule

// File: rtl/add3_acc_sched.sv
// add3_acc_sched: job sequencer that streams operand beats into per-lane accumulators
// and presents the registered psums on a valid/ready result port.
module add3_acc_sched #(
  parameter int LANES = add3_pkg::LANES,
  parameter int DW = add3_pkg::DW,
  parameter int AW = add3_pkg::AW,
  parameter int LEN_W = add3_pkg::LEN_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_act,
  input  logic [LANES*DW-1:0] in_wgt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*AW-1:0] out_psum,
  output logic                busy
);
  import add3_pkg::*;
  sched_state_t state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic cmd_hs, in_hs, out_hs, last;
  assign cmd_ready = state_q == S_IDLE;
  assign in_ready = state_q == S_RUN;
  assign out_valid = state_q == S_DONE;
  assign busy = state_q != S_IDLE;
  assign cmd_hs = cmd_valid & cmd_ready;
  assign in_hs = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;
  assign last = cnt_q == len_q - LEN_W'(1);
  assign cnt_d = cmd_hs ? '0 : in_hs ? cnt_q + LEN_W'(1) : cnt_q;
  assign len_d = cmd_hs ? cmd_len : len_q;
  always_comb begin
    state_d = state_q;
    if (cmd_hs) state_d = (cmd_len == '0) ? S_DONE : S_RUN;
    else if (in_hs && last) state_d = S_DONE;
    else if (out_hs) state_d = S_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  // Accumulators clear on command accept, so out_psum is always the register contents.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    add3_lane_acc #(.DW(DW), .AW(AW)) u_lane (
      .clk(clk),
      .rst(rst),
      .clr(cmd_hs),
      .en(in_hs),
      .act(in_act[i*DW +: DW]),
      .wgt(in_wgt[i*DW +: DW]),
      .acc(out_psum[i*AW +: AW])
    );
  end
endmodule

// File: tb/tb_add3_acc_sched.sv
// tb_add3_acc_sched: directed checks of the add3 accumulator scheduler, including an AW=10 wrap instance.
module tb_add3_acc_sched;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, in_valid = 0, out_ready = 0;
  logic [7:0] cmd_len = 0;
  logic [23:0] in_act = 0, in_wgt = 0;
  logic cmd_ready, in_ready, out_valid, busy;
  logic [95:0] out_psum;
  logic w_cmd_valid = 0, w_in_valid = 0, w_out_ready = 0;
  logic [7:0] w_cmd_len = 0;
  logic [23:0] w_act = 0, w_wgt = 0;
  logic w_cmd_ready, w_in_ready, w_out_valid, w_busy;
  logic [29:0] w_psum;
  logic [95:0] held;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  add3_acc_sched u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wgt(in_wgt),
    .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum), .busy(busy)
  );

  add3_acc_sched #(.AW(10)) u_w10 (
    .clk(clk), .rst(rst), .cmd_valid(w_cmd_valid), .cmd_ready(w_cmd_ready), .cmd_len(w_cmd_len),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_act(w_act), .in_wgt(w_wgt),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_psum(w_psum), .busy(w_busy)
  );

  function automatic logic [23:0] p8(input int a0, input int a1, input int a2);
    return {8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [95:0] p32(input int a0, input int a1, input int a2);
    return {32'(a2), 32'(a1), 32'(a0)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic start(input int len);
    cmd_valid = 1;
    cmd_len = 8'(len);
    tick();
    cmd_valid = 0;
  endtask

  task automatic beat(input logic [23:0] a, input logic [23:0] w);
    in_valid = 1;
    in_act = a;
    in_wgt = w;
    tick();
    in_valid = 0;
    in_act = 24'hA5A5A5;
    in_wgt = 24'h5A5A5A;
  endtask

  task automatic consume;
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  initial begin
    tick();
    tick();
    check("reset_state", {out_psum, cmd_ready, in_ready, out_valid, busy}, {96'd0, 4'b1000});
    rst = 0;
    tick();
    // 1: single beat
    start(1);
    check("t1_run", {in_ready, out_valid, busy, cmd_ready}, 4'b1010);
    beat(p8(10, 50, 127), p8(20, 60, 1));
    check("t1_valid", {out_valid, in_ready, busy}, 3'b101);
    check("t1_psum", out_psum, p32(30, 110, 128));
    consume();
    check("t1_idle", {out_valid, cmd_ready, busy}, 3'b010);
    // 2: two beats cancelling to {0,0,-1}
    start(2);
    beat(p8(10, 50, 127), p8(20, 60, 1));
    check("t2_mid", {out_valid, in_ready}, 2'b01);
    beat(p8(-10, -50, -128), p8(-20, -60, -1));
    check("t2_valid", out_valid, 1);
    check("t2_psum", out_psum, p32(0, 0, -1));
    consume();
    // 3: zero-length job
    start(0);
    check("t3_flags", {in_ready, out_valid}, 2'b01);
    check("t3_psum", out_psum, 96'd0);
    consume();
    // 4: gaps between beats, back-pressured result
    start(3);
    beat(p8(127, 0, -128), p8(-128, 1, -128));
    tick();
    check("t4_gap1", {in_ready, out_valid}, 2'b10);
    beat(p8(127, 0, -128), p8(-128, 1, -128));
    tick();
    tick();
    check("t4_gap2", {in_ready, out_valid}, 2'b10);
    beat(p8(127, 0, -128), p8(-128, 1, -128));
    check("t4_psum", out_psum, p32(-3, 3, -768));
    cmd_valid = 1;
    cmd_len = 8'd5;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t4_hold_valid", {out_valid, cmd_ready, in_ready}, 3'b100);
      check("t4_hold_psum", out_psum, p32(-3, 3, -768));
    end
    cmd_valid = 0;
    consume();
    check("t4_done", {out_valid, cmd_ready}, 2'b01);
    held = out_psum;
    in_valid = 1;
    in_act = p8(1, 2, 3);
    in_wgt = p8(4, 5, 6);
    tick();
    in_valid = 0;
    check("idle_in_ignored", {out_psum, in_ready}, {held, 1'b0});
    // 5: reset mid-job
    start(4);
    beat(p8(5, 5, 5), p8(5, 5, 5));
    beat(p8(5, 5, 5), p8(5, 5, 5));
    rst = 1;
    #1;
    check("t5_async_rst", {out_psum, cmd_ready, in_ready, out_valid, busy}, {96'd0, 4'b1000});
    tick();
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t5_no_valid", {out_valid, cmd_ready}, 2'b01);
    end
    start(1);
    beat(p8(1, 1, 1), p8(1, 1, 1));
    check("t5_fresh", {out_valid, out_psum}, {1'b1, p32(2, 2, 2)});
    consume();
    // 6: AW=10 wraps 5*254 = 1270 to 246
    w_cmd_valid = 1;
    w_cmd_len = 8'd5;
    tick();
    w_cmd_valid = 0;
    w_in_valid = 1;
    w_act = p8(127, 127, 127);
    w_wgt = p8(127, 127, 127);
    for (int k = 0; k < 5; k++) tick();
    w_in_valid = 0;
    check("t6_valid", {w_out_valid, w_in_ready}, 2'b10);
    check("t6_wrap", w_psum, {10'd246, 10'd246, 10'd246});
    w_out_ready = 1;
    tick();
    w_out_ready = 0;
    check("t6_idle", {w_out_valid, w_cmd_ready}, 2'b01);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
